dmem_arbiter: RTL and testbench

Parametrised data-memory bus arbiter between the CPU datapath and `NCH` DMA-capable coprocessor channels. It replaces the single-channel hold/holdACK mux in front of data memory with the following features:
- a registered multi-requester arbiter;
- selectable fixed-priority or round-robin policy;
- an optional burst limit that forcibly returns the bus to the CPU.

`cpu_stall` drives the CPU's PC-register enable (active-low use).

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter: the CPU owns the bus by default; NCH DMA channels
// request it with level-sensitive hold lines and are granted one at a time.
// Policy is fixed priority (channel 0 highest) or round-robin. An optional
// burst limit forces the bus back to the CPU. Every grant is followed by a
// one-cycle RELEASE and a one-cycle IDLE, so the CPU gets at least two cycles.
module dmem_arbiter #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned RR        = 1,
  parameter int unsigned MAX_BURST = 0,
  localparam int unsigned GW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wd,
  input  logic [NCH-1:0]    hold,
  input  logic [NCH-1:0]    dma_we,
  input  logic [NCH*AW-1:0] dma_addr,
  input  logic [NCH*DW-1:0] dma_wd,
  output logic [NCH-1:0]    hold_ack,
  output logic              cpu_stall,
  output logic [GW-1:0]     grant_id,
  output logic              dmem_we,
  output logic [AW-1:0]     dmem_addr,
  output logic [DW-1:0]     dmem_wd
);

  // Burst counter only needs to reach MAX_BURST-1; it saturates at all-ones.
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [NCH-1:0]  hold_ack_q,  hold_ack_d;
  logic            cpu_stall_q, cpu_stall_d;
  logic [GW-1:0]   grant_id_q,  grant_id_d;
  logic [GW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [GW-1:0]   win_lo_s;     // lowest-index requester
  logic [GW-1:0]   win_hi_s;     // lowest requester at or above rr_ptr
  logic            win_hi_found_s;
  logic [GW-1:0]   winner_s;
  logic [NCH-1:0]  win_onehot_s;
  logic [GW-1:0]   next_ptr_s;
  logic            hold_sel_s;   // hold line of the granted channel
  logic            burst_hit_s;
  logic            sel_we_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wd_s;

  // Winner search: scanning downward lets the lowest qualifying index win.
  // The round-robin wrap is the "at or above pointer" search falling back
  // to the plain lowest-index search.
  always_comb begin
    win_lo_s       = '0;
    win_hi_s       = '0;
    win_hi_found_s = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      win_lo_s       = hold[i] ? GW'(i) : win_lo_s;
      win_hi_s       = (hold[i] && (GW'(i) >= rr_ptr_q)) ? GW'(i) : win_hi_s;
      win_hi_found_s = win_hi_found_s | (hold[i] & (GW'(i) >= rr_ptr_q));
    end
    winner_s   = ((RR != 0) && win_hi_found_s) ? win_hi_s : win_lo_s;
    next_ptr_s = (winner_s == GW'(NCH - 1)) ? '0 : (winner_s + GW'(1));
    for (int i = 0; i < int'(NCH); i++) begin
      win_onehot_s[i] = (winner_s == GW'(i));
    end
  end

  // Select the granted channel's request and memory-access slice.
  always_comb begin
    hold_sel_s = 1'b0;
    sel_we_s   = 1'b0;
    sel_addr_s = '0;
    sel_wd_s   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      hold_sel_s = (grant_id_q == GW'(i)) ? hold[i]               : hold_sel_s;
      sel_we_s   = (grant_id_q == GW'(i)) ? dma_we[i]             : sel_we_s;
      sel_addr_s = (grant_id_q == GW'(i)) ? dma_addr[i*AW +: AW]  : sel_addr_s;
      sel_wd_s   = (grant_id_q == GW'(i)) ? dma_wd[i*DW +: DW]    : sel_wd_s;
    end
    burst_hit_s = (MAX_BURST != 0) && (burst_cnt_q == CW'(MAX_BURST - 1));
  end

  // Next-state logic for the IDLE -> GRANT -> RELEASE cycle.
  always_comb begin
    state_d     = state_q;
    hold_ack_d  = hold_ack_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|hold) begin
          state_d     = ST_GRANT;
          hold_ack_d  = win_onehot_s;
          grant_id_d  = winner_s;
          burst_cnt_d = '0;
          rr_ptr_d    = (RR != 0) ? next_ptr_s : rr_ptr_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A hold drop and a burst-limit hit in the same cycle look identical.
        if (!hold_sel_s || burst_hit_s) begin
          state_d    = ST_RELEASE;
          hold_ack_d = '0;
        end else begin
          state_d     = ST_GRANT;
          burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q : (burst_cnt_q + CW'(1));
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        hold_ack_d = '0;
      end
    endcase
    cpu_stall_d = |hold_ack_d;
  end

  // State and grant registers; reset drops the grant asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_ack_q  <= '0;
      cpu_stall_q <= 1'b0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_ack_q  <= hold_ack_d;
      cpu_stall_q <= cpu_stall_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Memory-path mux: granted channel in GRANT, CPU otherwise, no pipelining.
  always_comb begin
    if (state_q == ST_GRANT) begin
      dmem_we   = sel_we_s;
      dmem_addr = sel_addr_s;
      dmem_wd   = sel_wd_s;
    end else begin
      dmem_we   = cpu_we;
      dmem_addr = cpu_addr;
      dmem_wd   = cpu_wd;
    end
  end

  assign hold_ack  = hold_ack_q;
  assign cpu_stall = cpu_stall_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances share the stimulus
//   a: round-robin, unlimited burst
//   b: round-robin, MAX_BURST=4
//   c: fixed priority, MAX_BURST=4
// Expected per-cycle bus state is queued when hold is driven and checked
// one cycle later.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [1:0]  hold;
  logic [1:0]  dma_we;
  logic [63:0] dma_addr;
  logic [63:0] dma_wd;

  logic [1:0]  a_ack, b_ack, c_ack;
  logic        a_stall, b_stall, c_stall;
  logic [0:0]  a_gid, b_gid, c_gid;
  logic        a_we, b_we, c_we;
  logic [31:0] a_addr, b_addr, c_addr;
  logic [31:0] a_wd, b_wd, c_wd;

  typedef struct packed {
    logic [1:0]  ack;
    logic        stall;
    logic        we;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_arbiter #(.NCH(2), .DW(32), .AW(32), .RR(1), .MAX_BURST(0)) dut_a (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .hold(hold), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .hold_ack(a_ack), .cpu_stall(a_stall), .grant_id(a_gid),
    .dmem_we(a_we), .dmem_addr(a_addr), .dmem_wd(a_wd));

  dmem_arbiter #(.NCH(2), .DW(32), .AW(32), .RR(1), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .hold(hold), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .hold_ack(b_ack), .cpu_stall(b_stall), .grant_id(b_gid),
    .dmem_we(b_we), .dmem_addr(b_addr), .dmem_wd(b_wd));

  dmem_arbiter #(.NCH(2), .DW(32), .AW(32), .RR(0), .MAX_BURST(4)) dut_c (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .hold(hold), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .hold_ack(c_ack), .cpu_stall(c_stall), .grant_id(c_gid),
    .dmem_we(c_we), .dmem_addr(c_addr), .dmem_wd(c_wd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus state implied by a given grant vector: ch0 at 0x1000, ch1 at 0x2000,
  // both DMA channels write; CPU reads at 0x100.
  function automatic exp_t mk(input logic [1:0] ack);
    exp_t e;
    e.ack   = ack;
    e.stall = |ack;
    e.we    = (ack != 2'b00);
    e.addr  = (ack == 2'b01) ? 32'h0000_1000 :
              (ack == 2'b10) ? 32'h0000_2000 : 32'h0000_0100;
    return e;
  endfunction

  task automatic do_reset();
    hold = 2'b00;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst  = 1'b1;
    hold = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (a_ack !== 2'b00) begin n_err++; $display("FAIL reset_ack got=%b want=00", a_ack); end
    n_cmp++;
    if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", a_stall); end
    n_cmp++;
    if (a_addr !== 32'h0000_0100) begin n_err++; $display("FAIL reset_addr got=%h want=00000100", a_addr); end
    rst = 1'b0;
    sbq.push_back(mk(2'b01));
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++;
    if (a_ack !== e.ack || a_addr !== e.addr) begin
      n_err++;
      $display("FAIL reset_first_grant got ack=%b addr=%h want ack=%b addr=%h", a_ack, a_addr, e.ack, e.addr);
    end
    hold = 2'b00;
  endtask

  task automatic test_single_grant();
    exp_t e;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      hold = (j < 5) ? 2'b10 : 2'b00;
      sbq.push_back(mk((j < 5) ? 2'b10 : 2'b00));
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++;
      if (a_ack !== e.ack || a_stall !== e.stall || a_we !== e.we || a_addr !== e.addr) begin
        n_err++;
        $display("FAIL single_grant cyc=%0d got ack=%b stall=%b we=%b addr=%h want ack=%b stall=%b we=%b addr=%h",
                 j, a_ack, a_stall, a_we, a_addr, e.ack, e.stall, e.we, e.addr);
      end
      if (j < 5) begin
        n_cmp++;
        if (a_gid !== 1'b1) begin n_err++; $display("FAIL single_grant_id cyc=%0d got=%0d want=1", j, a_gid); end
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    hold = 2'b11;
    for (int j = 0; j < 24; j++) begin
      sbq.push_back(mk(((j % 6) < 4) ? (((j / 6) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00));
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++;
      if (b_ack !== e.ack || b_stall !== e.stall || b_we !== e.we || b_addr !== e.addr) begin
        n_err++;
        $display("FAIL round_robin cyc=%0d got ack=%b stall=%b we=%b addr=%h want ack=%b stall=%b we=%b addr=%h",
                 j, b_ack, b_stall, b_we, b_addr, e.ack, e.stall, e.we, e.addr);
      end
    end
    hold = 2'b00;
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    do_reset();
    hold = 2'b11;
    for (int j = 0; j < 24; j++) begin
      sbq.push_back(mk(((j % 6) < 4) ? 2'b01 : 2'b00));
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++;
      if (c_ack !== e.ack || c_stall !== e.stall || c_we !== e.we || c_addr !== e.addr) begin
        n_err++;
        $display("FAIL fixed_priority cyc=%0d got ack=%b stall=%b we=%b addr=%h want ack=%b stall=%b we=%b addr=%h",
                 j, c_ack, c_stall, c_we, c_addr, e.ack, e.stall, e.we, e.addr);
      end
    end
    hold = 2'b00;
  endtask

  task automatic test_burst_limit();
    exp_t e;
    do_reset();
    hold = 2'b01;
    for (int j = 0; j < 20; j++) begin
      sbq.push_back(mk(((j % 6) < 4) ? 2'b01 : 2'b00));
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++;
      if (b_ack !== e.ack || b_stall !== e.stall || b_addr !== e.addr) begin
        n_err++;
        $display("FAIL burst_limit cyc=%0d got ack=%b stall=%b addr=%h want ack=%b stall=%b addr=%h",
                 j, b_ack, b_stall, b_addr, e.ack, e.stall, e.addr);
      end
    end
    hold = 2'b00;
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    do_reset();
    hold = 2'b01;
    for (int j = 0; j < 3; j++) begin
      sbq.push_back(mk(2'b01));
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++;
      if (a_ack !== e.ack || a_addr !== e.addr) begin
        n_err++;
        $display("FAIL mid_grant_pre cyc=%0d got ack=%b addr=%h want ack=%b addr=%h", j, a_ack, a_addr, e.ack, e.addr);
      end
    end
    // Third granted cycle: reset lands between clock edges.
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_ack !== 2'b00 || a_stall !== 1'b0 || a_addr !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL mid_grant_async got ack=%b stall=%b addr=%h want ack=00 stall=0 addr=00000100", a_ack, a_stall, a_addr);
    end
    rst  = 1'b0;
    hold = 2'b11;
    sbq.push_back(mk(2'b01));
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++;
    if (a_ack !== e.ack || a_addr !== e.addr || a_gid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_grant_regrant got ack=%b addr=%h gid=%0d want ack=%b addr=%h gid=0", a_ack, a_addr, a_gid, e.ack, e.addr);
    end
    hold = 2'b00;
  endtask

  initial begin
    rst      = 1'b1;
    hold     = 2'b00;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0100;
    cpu_wd   = 32'hCAFE_0000;
    dma_we   = 2'b11;
    dma_addr = {32'h0000_2000, 32'h0000_1000};
    dma_wd   = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    test_reset();
    test_single_grant();
    test_round_robin();
    test_fixed_priority();
    test_burst_limit();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
